bp_io_cmd_scheduler: RTL and testbench
======================================

Name: bp_io_cmd_scheduler

Overview:
- Shares a single IO-NoC command/response channel pair (the CCE-side memory-message port of the IO tile's wormhole link) among num_req_p command sources.
- Round-robin arbitrates commands, enforces an outstanding-request credit limit and steers in-order responses back to the issuing requester via a requester-ID FIFO.
- Sits between the IO CCE / DMA-style sources and the cce-to-mem link.

Parameters:
- num_req_p, 2, number of requesters (≥1).
- msg_width_p, 128, width of command and response messages (opaque payload).
- max_credits_p, 16, max outstanding commands; also tag FIFO depth.
- lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), derived requester-ID width.
- credit_width_lp, `BSG_WIDTH(max_credits_p), derived credit counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_i  in  num_req_p*msg_width_p  per-requester command; requester r at bits [r*msg_width_p +: msg_width_p].
- cmd_v_i  in  num_req_p  command valid per requester.
- cmd_yumi_o  out  num_req_p  command consumed, one-hot or zero.
- io_cmd_o  out  msg_width_p  granted command.
- io_cmd_v_o  out  1  io_cmd_o valid.
- io_cmd_ready_i  in  1  downstream ready.
- io_resp_i  in  msg_width_p  response from link.
- io_resp_v_i  in  1  response valid.
- io_resp_yumi_o  out  1  response consumed.
- resp_o  out  msg_width_p  response broadcast to all requesters (equals io_resp_i).
- resp_v_o  out  num_req_p  response valid, one-hot to owning requester.
- resp_ready_i  in  num_req_p  per-requester response ready.
- credits_empty_o  out  1  no commands outstanding (for fence/drain).
- err_o  out  1  sticky: response arrived with no outstanding command.
- stall_cycles_o  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert): rr pointer=0, credit count=0, tag FIFO empty, err_o=0, stall counter=0. During/after reset: cmd_yumi_o=0, io_cmd_v_o=0, io_resp_yumi_o=0, resp_v_o=0, credits_empty_o=1.
- credit_avail = (count < max_credits_p); FIFO full coincides with count==max_credits_p.
- Arbitration: combinational round robin over cmd_v_i starting at rr pointer. io_cmd_v_o = |cmd_v_i & credit_avail; io_cmd_o = cmd of winner. io_cmd_v_o never depends on io_cmd_ready_i.
- Send: when io_cmd_v_o & io_cmd_ready_i, cmd_yumi_o[winner]=1 same cycle (zero-latency pass-through), winner ID enqueued, count+1, rr pointer := winner+1 mod num_req_p. No handshake → pointer unchanged.
- Response: head = FIFO head ID. resp_v_o[head] = io_resp_v_i & ~fifo_empty; io_resp_yumi_o = io_resp_v_i & resp_ready_i[head] & ~fifo_empty. On yumi: dequeue, count−1. Responses are in issue order; no reordering.
- Send and response in same cycle: count unchanged; FIFO enq/deq both occur; legal even when FIFO is full (dequeue frees slot, but send is still blocked that cycle because credit_avail is evaluated on registered count).
- Orphan response (io_resp_v_i & fifo_empty): io_resp_yumi_o=1 (drop), resp_v_o=0, err_o set until reset, count stays 0 (no underflow).
- credits_empty_o = (count==0), registered-state based.
- Count saturates logically at max_credits_p; overflow is impossible by construction.
- num_req_p=1: pointer is constant 0, arbiter degenerates to pass-through.

Optional Feature:
- Macro BP_IO_CMD_SCHED_PERF_EN.
- Defined: stall_cycles_o increments (saturating at 2^32−1) each cycle with |cmd_v_i & ~credit_avail.
- Undefined: counter logic is absent and stall_cycles_o is tied to 0.

Test Plan:
- Single request: req0 valid with cmd=0xA5, ready=1 → io_cmd_o=0xA5 and cmd_yumi_o=01 in the same cycle, credits_empty_o=0 next cycle; then resp → resp_v_o=01, credits_empty_o=1.
- Fairness: both requesters held valid, ready=1 for 6 cycles → grants alternate 0,1,0,1,0,1; FIFO order matches; responses steered 0,1,0,1,0,1.
- Credit limit: max_credits_p=4, no responses, constant valid → exactly 4 sends, then io_cmd_v_o=0 (perf build: stall_cycles_o counts each stalled cycle); one response → exactly one further send the cycle after.
- Backpressure: io_cmd_ready_i=0 for 3 cycles with req1 valid → no yumi, rr pointer and count unchanged; resp_ready_i[owner]=0 → io_resp_yumi_o=0, response held.
- Simultaneous send+response at count=2 → count stays 2, FIFO order preserved.
- Orphan response after reset → io_resp_yumi_o=1, err_o=1 sticky, credits_empty_o stays 1; async reset mid-traffic → all outputs 0 immediately, credits_empty_o=1.

Source files
------------

// File: rtl/bp_io_cmd_scheduler.sv
// Round-robin IO command scheduler with an outstanding-credit limit and an in-order requester-ID FIFO.
// Define BP_IO_CMD_SCHED_PERF_EN to enable the credit-stall performance counter on stall_cycles_o.
module bp_io_cmd_scheduler #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 128,
    parameter int max_credits_p = 16,
    localparam int lg_num_req_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int credit_width_lp = $clog2(max_credits_p + 1),
    localparam int ptr_width_lp    = (max_credits_p > 1) ? $clog2(max_credits_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_req_p*msg_width_p-1:0] cmd_i,
    input  logic [num_req_p-1:0]             cmd_v_i,
    output logic [num_req_p-1:0]             cmd_yumi_o,
    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_ready_i,
    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_yumi_o,
    output logic [msg_width_p-1:0]           resp_o,
    output logic [num_req_p-1:0]             resp_v_o,
    input  logic [num_req_p-1:0]             resp_ready_i,
    output logic                             credits_empty_o,
    output logic                             err_o,
    output logic [31:0]                      stall_cycles_o
);

    logic [lg_num_req_lp-1:0]   rr_q, rr_d;
    logic [credit_width_lp-1:0] count_q, count_d;
    logic [ptr_width_lp-1:0]    wptr_q, wptr_d;
    logic [ptr_width_lp-1:0]    rptr_q, rptr_d;
    logic [lg_num_req_lp-1:0]   tag_mem_q [max_credits_p];
    logic [lg_num_req_lp-1:0]   tag_mem_d [max_credits_p];
    logic                       err_q, err_d;

    logic                       any_v_s;
    logic                       credit_avail_s;
    logic                       fifo_empty_s;
    logic                       send_s;
    logic                       resp_fire_s;
    logic                       orphan_s;
    logic [lg_num_req_lp-1:0]   winner_s;
    logic [lg_num_req_lp-1:0]   head_s;
    logic                       head_ready_s;

    assign any_v_s        = |cmd_v_i;
    assign credit_avail_s = (count_q < credit_width_lp'(max_credits_p));
    assign fifo_empty_s   = (count_q == '0);
    assign head_s         = tag_mem_q[rptr_q];

    // Round-robin search starting at the pointer; the first valid requester wins.
    always_comb begin
        int   sum_v;
        int   idx_v;
        logic found_v;
        winner_s = '0;
        found_v  = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            sum_v    = int'(rr_q) + i;
            idx_v    = (sum_v >= num_req_p) ? (sum_v - num_req_p) : sum_v;
            winner_s = (cmd_v_i[idx_v] && !found_v) ? idx_v[lg_num_req_lp-1:0] : winner_s;
            found_v  = found_v | cmd_v_i[idx_v];
        end
    end

    // Command channel: outputs held low while reset is asserted, never gated by ready.
    always_comb begin
        io_cmd_o   = cmd_i[int'(winner_s)*msg_width_p +: msg_width_p];
        io_cmd_v_o = ~reset_i & any_v_s & credit_avail_s;
        send_s     = io_cmd_v_o & io_cmd_ready_i;
        for (int r = 0; r < num_req_p; r++) begin
            cmd_yumi_o[r] = send_s & (winner_s == lg_num_req_lp'(r));
        end
    end

    // Response steering to the FIFO head; orphans are dropped with yumi.
    always_comb begin
        head_ready_s = 1'b0;
        for (int r = 0; r < num_req_p; r++) begin
            head_ready_s = head_ready_s | (resp_ready_i[r] & (head_s == lg_num_req_lp'(r)));
        end
        resp_fire_s    = ~reset_i & io_resp_v_i & ~fifo_empty_s & head_ready_s;
        orphan_s       = ~reset_i & io_resp_v_i & fifo_empty_s;
        io_resp_yumi_o = resp_fire_s | orphan_s;
        resp_o         = io_resp_i;
        for (int r = 0; r < num_req_p; r++) begin
            resp_v_o[r] = ~reset_i & io_resp_v_i & ~fifo_empty_s & (head_s == lg_num_req_lp'(r));
        end
    end

    // Next-state for pointer, credit count, tag FIFO and sticky error.
    always_comb begin
        rr_d   = send_s ? ((winner_s == lg_num_req_lp'(num_req_p - 1)) ? '0 : winner_s + lg_num_req_lp'(1)) : rr_q;
        wptr_d = send_s ? ((wptr_q == ptr_width_lp'(max_credits_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1)) : wptr_q;
        rptr_d = resp_fire_s ? ((rptr_q == ptr_width_lp'(max_credits_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1)) : rptr_q;
        for (int k = 0; k < max_credits_p; k++) begin
            tag_mem_d[k] = (send_s && (wptr_q == ptr_width_lp'(k))) ? winner_s : tag_mem_q[k];
        end
        case ({send_s, resp_fire_s})
            2'b10:   count_d = count_q + credit_width_lp'(1);
            2'b01:   count_d = count_q - credit_width_lp'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | orphan_s;
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q    <= '0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
            for (int k = 0; k < max_credits_p; k++) begin
                tag_mem_q[k] <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            err_q   <= err_d;
            for (int k = 0; k < max_credits_p; k++) begin
                tag_mem_q[k] <= tag_mem_d[k];
            end
        end
    end

    assign credits_empty_o = fifo_empty_s;
    assign err_o           = err_q;

`ifdef BP_IO_CMD_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of cycles where a command waits only on credits.
    always_comb begin
        stall_d = (any_v_s && !credit_avail_s && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
    end

    // Stall counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_io_cmd_scheduler.sv
// Self-checking bench for bp_io_cmd_scheduler: model of rr pointer, credit count and an ID scoreboard queue.
module tb_bp_io_cmd_scheduler;

    localparam int NR = 2;
    localparam int W  = 128;
    localparam int MC = 4;

    logic              clk;
    logic              reset;
    logic [NR*W-1:0]   cmd;
    logic [NR-1:0]     cmd_v;
    logic [NR-1:0]     cmd_yumi;
    logic [W-1:0]      io_cmd;
    logic              io_cmd_v;
    logic              io_cmd_ready;
    logic [W-1:0]      io_resp;
    logic              io_resp_v;
    logic              io_resp_yumi;
    logic [W-1:0]      resp;
    logic [NR-1:0]     resp_v;
    logic [NR-1:0]     resp_ready;
    logic              credits_empty;
    logic              err;
    logic [31:0]       stall_cycles;

    int checks = 0;
    int errors = 0;
    int m_rr = 0;
    int m_count = 0;
    int m_stall = 0;
    int id_q[$];

    bp_io_cmd_scheduler #(.num_req_p(NR), .msg_width_p(W), .max_credits_p(MC)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_yumi_o(cmd_yumi),
        .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_i(io_cmd_ready),
        .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(io_resp_yumi),
        .resp_o(resp), .resp_v_o(resp_v), .resp_ready_i(resp_ready),
        .credits_empty_o(credits_empty), .err_o(err), .stall_cycles_o(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_winner();
        for (int i = 0; i < NR; i++) begin
            int idx;
            idx = (m_rr + i) % NR;
            if (cmd_v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int id);
        logic [NR-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Advance one clock; the model mirrors the intended behaviour from the driven inputs.
    task automatic tick();
        bit snd;
        bit rf;
        int w;
        w   = model_winner();
        snd = !reset && (w >= 0) && (m_count < MC) && io_cmd_ready;
        rf  = 1'b0;
        if (!reset && io_resp_v && id_q.size() > 0) rf = resp_ready[id_q[0]];
        if (!reset && cmd_v != '0 && m_count >= MC) m_stall++;
        if (rf) void'(id_q.pop_front());
        if (snd) begin
            id_q.push_back(w);
            m_rr = (w + 1) % NR;
        end
        m_count = m_count + (snd ? 1 : 0) - (rf ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cmd_v = '0;
        io_resp_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rr = 0;
        m_count = 0;
        m_stall = 0;
        id_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd = '0;
        cmd_v = 2'b11;
        io_cmd_ready = 1'b1;
        io_resp = 128'h1234;
        io_resp_v = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++; if (cmd_yumi !== 2'b00) begin errors++; $display("FAIL reset_yumi: got %b expected 00", cmd_yumi); end
        checks++; if (io_cmd_v !== 1'b0) begin errors++; $display("FAIL reset_cmd_v: got %b expected 0", io_cmd_v); end
        checks++; if (io_resp_yumi !== 1'b0) begin errors++; $display("FAIL reset_resp_yumi: got %b expected 0", io_resp_yumi); end
        checks++; if (resp_v !== 2'b00) begin errors++; $display("FAIL reset_resp_v: got %b expected 00", resp_v); end
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL reset_credits_empty: got %b expected 1", credits_empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
        @(negedge clk);
        cmd_v = '0;
        io_resp_v = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (io_cmd_v !== 1'b0) begin errors++; $display("FAIL post_reset_cmd_v: got %b expected 0", io_cmd_v); end
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b expected 1", credits_empty); end
    endtask

    task automatic test_single();
        cmd[0 +: W] = 128'hA5;
        cmd_v = 2'b01;
        io_cmd_ready = 1'b1;
        #1;
        checks++; if (io_cmd_v !== 1'b1) begin errors++; $display("FAIL single_cmd_v: got %b expected 1", io_cmd_v); end
        checks++; if (io_cmd !== 128'hA5) begin errors++; $display("FAIL single_cmd: got %h expected a5", io_cmd); end
        checks++; if (cmd_yumi !== 2'b01) begin errors++; $display("FAIL single_yumi: got %b expected 01", cmd_yumi); end
        tick();
        cmd_v = '0;
        #1;
        checks++; if (credits_empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %b expected 0", credits_empty); end
        io_resp = 128'hBEEF;
        io_resp_v = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++; if (resp_v !== 2'b01) begin errors++; $display("FAIL single_resp_v: got %b expected 01", resp_v); end
        checks++; if (io_resp_yumi !== 1'b1) begin errors++; $display("FAIL single_resp_yumi: got %b expected 1", io_resp_yumi); end
        checks++; if (resp !== 128'hBEEF) begin errors++; $display("FAIL single_resp_data: got %h expected beef", resp); end
        tick();
        io_resp_v = 1'b0;
        #1;
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", credits_empty); end
    endtask

    task automatic drain(input string tag);
        io_resp_v = 1'b1;
        resp_ready = 2'b11;
        for (int k = 0; k < 8 && id_q.size() > 0; k++) begin
            #1;
            checks++; if (resp_v !== onehot(id_q[0])) begin errors++; $display("FAIL %s_drain_steer: got %b expected %b", tag, resp_v, onehot(id_q[0])); end
            tick();
        end
        io_resp_v = 1'b0;
        #1;
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL %s_drain_empty: got %b expected 1", tag, credits_empty); end
    endtask

    task automatic test_fairness();
        apply_reset();
        cmd[0 +: W] = 128'h100;
        cmd[W +: W] = 128'h101;
        io_cmd_ready = 1'b1;
        resp_ready = 2'b11;
        for (int i = 0; i < 6; i++) begin
            cmd_v = 2'b11;
            io_resp_v = (i > 0);
            io_resp = 128'(i);
            #1;
            checks++; if (cmd_yumi !== onehot(i % 2)) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", i, cmd_yumi, onehot(i % 2)); end
            checks++; if (io_cmd !== 128'(256 + (i % 2))) begin errors++; $display("FAIL fair_cmd_%0d: got %h expected %h", i, io_cmd, 256 + (i % 2)); end
            if (i > 0) begin
                checks++; if (resp_v !== onehot(id_q[0])) begin errors++; $display("FAIL fair_steer_%0d: got %b expected %b", i, resp_v, onehot(id_q[0])); end
                checks++; if (io_resp_yumi !== 1'b1) begin errors++; $display("FAIL fair_resp_yumi_%0d: got %b expected 1", i, io_resp_yumi); end
            end
            tick();
        end
        cmd_v = '0;
        drain("fair");
    endtask

    task automatic test_credit_limit();
        int sends;
        int exp_stall;
        sends = 0;
        cmd_v = 2'b11;
        io_cmd_ready = 1'b1;
        io_resp_v = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++; if (io_cmd_v !== 1'(m_count < MC)) begin errors++; $display("FAIL credit_cmd_v_%0d: got %b expected %b", i, io_cmd_v, m_count < MC); end
            if (cmd_yumi != 2'b00) sends++;
            tick();
        end
        checks++; if (sends !== 4) begin errors++; $display("FAIL credit_sends: got %0d expected 4", sends); end
`ifdef BP_IO_CMD_SCHED_PERF_EN
        exp_stall = m_stall;
`else
        exp_stall = 0;
`endif
        checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL credit_stall: got %0d expected %0d", stall_cycles, exp_stall); end
        io_resp_v = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++; if (io_cmd_v !== 1'b0) begin errors++; $display("FAIL credit_full_blocked: got %b expected 0", io_cmd_v); end
        checks++; if (io_resp_yumi !== 1'b1) begin errors++; $display("FAIL credit_resp_yumi: got %b expected 1", io_resp_yumi); end
        tick();
        io_resp_v = 1'b0;
        #1;
        checks++; if (cmd_yumi !== onehot(m_rr)) begin errors++; $display("FAIL credit_one_more: got %b expected %b", cmd_yumi, onehot(m_rr)); end
        tick();
        #1;
        checks++; if (io_cmd_v !== 1'b0) begin errors++; $display("FAIL credit_blocked_again: got %b expected 0", io_cmd_v); end
        cmd_v = '0;
        drain("credit");
    endtask

    task automatic test_backpressure();
        int owner;
        cmd_v = 2'b10;
        io_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (io_cmd_v !== 1'b1) begin errors++; $display("FAIL bp_cmd_v_%0d: got %b expected 1", i, io_cmd_v); end
            checks++; if (cmd_yumi !== 2'b00) begin errors++; $display("FAIL bp_no_yumi_%0d: got %b expected 00", i, cmd_yumi); end
            tick();
        end
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL bp_count_unchanged: got %b expected 1", credits_empty); end
        cmd_v = 2'b11;
        io_cmd_ready = 1'b1;
        #1;
        checks++; if (cmd_yumi !== onehot(m_rr)) begin errors++; $display("FAIL bp_rr_unchanged: got %b expected %b", cmd_yumi, onehot(m_rr)); end
        tick();
        cmd_v = '0;
        owner = id_q[0];
        io_resp_v = 1'b1;
        resp_ready = ~onehot(owner);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (resp_v !== onehot(owner)) begin errors++; $display("FAIL bp_resp_held_%0d: got %b expected %b", i, resp_v, onehot(owner)); end
            checks++; if (io_resp_yumi !== 1'b0) begin errors++; $display("FAIL bp_resp_no_yumi_%0d: got %b expected 0", i, io_resp_yumi); end
            tick();
        end
        resp_ready = 2'b11;
        #1;
        checks++; if (io_resp_yumi !== 1'b1) begin errors++; $display("FAIL bp_resp_release: got %b expected 1", io_resp_yumi); end
        tick();
        io_resp_v = 1'b0;
        #1;
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL bp_empty_after: got %b expected 1", credits_empty); end
    endtask

    task automatic test_simultaneous();
        int n;
        cmd_v = 2'b01;
        io_cmd_ready = 1'b1;
        tick();
        tick();
        cmd_v = 2'b10;
        io_resp_v = 1'b1;
        resp_ready = 2'b11;
        #1;
        checks++; if (cmd_yumi !== 2'b10) begin errors++; $display("FAIL simul_yumi: got %b expected 10", cmd_yumi); end
        checks++; if (resp_v !== 2'b01) begin errors++; $display("FAIL simul_resp_v: got %b expected 01", resp_v); end
        checks++; if (io_resp_yumi !== 1'b1) begin errors++; $display("FAIL simul_resp_yumi: got %b expected 1", io_resp_yumi); end
        tick();
        cmd_v = '0;
        io_resp_v = 1'b0;
        #1;
        checks++; if (credits_empty !== 1'b0) begin errors++; $display("FAIL simul_not_empty: got %b expected 0", credits_empty); end
        n = 0;
        io_resp_v = 1'b1;
        for (int k = 0; k < 6 && credits_empty === 1'b0; k++) begin
            #1;
            checks++; if (resp_v !== onehot(n == 0 ? 0 : 1)) begin errors++; $display("FAIL simul_order_%0d: got %b expected %b", n, resp_v, onehot(n == 0 ? 0 : 1)); end
            n++;
            tick();
        end
        io_resp_v = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL simul_count: got %0d responses expected 2", n); end
    endtask

    task automatic test_orphan_and_reset();
        apply_reset();
        io_resp_v = 1'b1;
        resp_ready = 2'b00;
        #1;
        checks++; if (io_resp_yumi !== 1'b1) begin errors++; $display("FAIL orphan_yumi: got %b expected 1", io_resp_yumi); end
        checks++; if (resp_v !== 2'b00) begin errors++; $display("FAIL orphan_resp_v: got %b expected 00", resp_v); end
        tick();
        io_resp_v = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_err: got %b expected 1", err); end
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL orphan_empty: got %b expected 1", credits_empty); end
        cmd_v = 2'b11;
        io_cmd_ready = 1'b1;
        tick();
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err); end
        io_resp_v = 1'b1;
        resp_ready = 2'b11;
        #1;
        reset = 1'b1;
        #1;
        checks++; if (io_cmd_v !== 1'b0) begin errors++; $display("FAIL async_cmd_v: got %b expected 0", io_cmd_v); end
        checks++; if (cmd_yumi !== 2'b00) begin errors++; $display("FAIL async_yumi: got %b expected 00", cmd_yumi); end
        checks++; if (resp_v !== 2'b00) begin errors++; $display("FAIL async_resp_v: got %b expected 00", resp_v); end
        checks++; if (io_resp_yumi !== 1'b0) begin errors++; $display("FAIL async_resp_yumi: got %b expected 0", io_resp_yumi); end
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL async_empty: got %b expected 1", credits_empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", err); end
        @(negedge clk);
        cmd_v = '0;
        io_resp_v = 1'b0;
        reset = 1'b0;
        m_rr = 0;
        m_count = 0;
        m_stall = 0;
        id_q.delete();
        #1;
        checks++; if (credits_empty !== 1'b1) begin errors++; $display("FAIL async_post_empty: got %b expected 1", credits_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_limit();
        test_backpressure();
        test_simultaneous();
        test_orphan_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
